// File: rtl/csidh_ise_pipe.sv
// csidh_ise_pipe: two-stage CSIDH ISE datapath computing sub/subadd/andadd/carry against a modulus limb table.
// The carry operation and its shifter are built only when CSIDH_ISE_CARRY_EN is defined.
module csidh_ise_pipe #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NLIMB = 9,
  parameter int unsigned IMMW  = 4,
  parameter int unsigned RADIX = 57,
  parameter logic [NLIMB*XLEN-1:0] P_LIMBS = {
    64'h0065B48E8F740F89, 64'h017FF91561A2BC7C, 64'h01312AD0B420EBB7,
    64'h00446212D7DFE634, 64'h01322C9CDA7AAC6C, 64'h00ACFE6AA0EA2CE6,
    64'h003307C2D3C9709C, 64'h010DFA2BD6541A8D, 64'h0181B90533C6C87B}
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [IMMW-1:0] imm,
  input  logic            op_csidh_sub,
  input  logic            op_csidh_subadd,
  input  logic            op_csidh_andadd,
  input  logic            op_csidh_carry,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rd
);

  logic [XLEN-1:0] limb;
  logic [XLEN-1:0] s1_diff;
  logic [XLEN-1:0] s1_and;
  logic [XLEN-1:0] s1_rs2;
  logic [XLEN-1:0] s2_sum;
  logic            s1_valid;
  logic            s1_sub;
  logic            s1_subadd;
  logic            s1_andadd;
  logic            xfer;
  logic            accept;

`ifdef CSIDH_ISE_CARRY_EN
  logic [XLEN-1:0] s1_sh;
  logic            s1_carry;
`else
  logic            unused_carry;
  assign unused_carry = op_csidh_carry;
`endif

  assign xfer      = s1_valid && (!rsp_valid || rsp_ready);
  assign req_ready = !s1_valid || xfer;
  assign accept    = req_valid && req_ready;

  // Limb table lookup; indices past the table select zero
  always_comb begin
    limb = '0;
    for (int unsigned i = 0; i < NLIMB; i++) begin
      if (imm == IMMW'(i)) limb = P_LIMBS[i*XLEN +: XLEN];
    end
  end

  // Stage 1: operands, op flags and the rs1-derived terms
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      s1_valid  <= 1'b0;
      s1_sub    <= 1'b0;
      s1_subadd <= 1'b0;
      s1_andadd <= 1'b0;
      s1_rs2    <= '0;
      s1_diff   <= '0;
      s1_and    <= '0;
`ifdef CSIDH_ISE_CARRY_EN
      s1_carry  <= 1'b0;
      s1_sh     <= '0;
`endif
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_sub    <= op_csidh_sub;
      s1_subadd <= op_csidh_subadd;
      s1_andadd <= op_csidh_andadd;
      s1_rs2    <= rs2;
      s1_diff   <= rs1 - limb;
      s1_and    <= rs1 & limb;
`ifdef CSIDH_ISE_CARRY_EN
      s1_carry  <= op_csidh_carry;
      s1_sh     <= XLEN'($signed(rs1) >>> RADIX);
`endif
    end else if (xfer) begin
      s1_valid  <= 1'b0;
    end
  end

  // Final sums, OR-merged across every asserted op
  always_comb begin
    s2_sum = '0;
    if (s1_sub)    s2_sum = s2_sum | s1_diff;
    if (s1_subadd) s2_sum = s2_sum | (s1_diff + s1_rs2);
    if (s1_andadd) s2_sum = s2_sum | (s1_and + s1_rs2);
`ifdef CSIDH_ISE_CARRY_EN
    if (s1_carry)  s2_sum = s2_sum | (s1_sh + s1_rs2);
`endif
  end

  // Stage 2: registered response, held while the consumer stalls
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rsp_valid <= 1'b0;
      rd        <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rd        <= s2_sum;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
